// File: rtl/px_ss_cfg_ctrl_if.sv
// Subsampler configuration bundle: skip counts and interval/remainder pairs per axis.
interface px_ss_if;
  logic [15:0] px_to_skip;
  logic [15:0] px_skip_interval;
  logic [15:0] add_px_skip_interval;
  logic [15:0] ln_to_skip;
  logic [15:0] ln_skip_interval;
  logic [15:0] add_ln_skip_interval;

  modport master (
    output px_to_skip, px_skip_interval, add_px_skip_interval,
    output ln_to_skip, ln_skip_interval, add_ln_skip_interval
  );
  modport slave (
    input px_to_skip, px_skip_interval, add_px_skip_interval,
    input ln_to_skip, ln_skip_interval, add_ln_skip_interval
  );
endinterface

// File: rtl/px_ss_cfg_ctrl.sv
// Scaling-request to subsampler-config controller: validate, divide per axis, apply atomically.
// Optional PX_SS_CFG_SOF_SYNC_EN holds the apply until a start-of-frame pulse.
module px_ss_cfg_ctrl (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        cfg_valid_i,
  output logic        cfg_ready_o,
  input  logic [15:0] in_px_i,
  input  logic [15:0] out_px_i,
  input  logic [15:0] in_ln_i,
  input  logic [15:0] out_ln_i,
  input  logic        sof_i,
  output logic        cfg_err_o,
  output logic        cfg_applied_o,
  output logic        busy_o,
  px_ss_if.master     ss_o
);

  typedef enum logic [2:0] {IDLE, CHK, DIV_PX, DIV_LN, PEND} state_e;

  state_e      state_q;
  logic [15:0] in_px_q, out_px_q, in_ln_q, out_ln_q;
  logic [15:0] skip_px_q, skip_ln_q;
  logic [15:0] q_px_q, r_px_q, q_ln_q, r_ln_q;
  logic [15:0] div_q_q, div_r_q;
  logic [3:0]  cnt_q;
  logic        rdy_q, busy_q, err_q, app_q;

  logic [15:0] div_d;
  logic [16:0] div_rsh;
  logic        div_ge;
  logic [15:0] div_q_d, div_r_d;
  logic        req_bad;
  logic        sof_hit;

`ifdef PX_SS_CFG_SOF_SYNC_EN
  assign sof_hit = sof_i;
`else
  logic sof_unused;
  assign sof_unused = sof_i;
  assign sof_hit    = 1'b1;
`endif

  assign cfg_ready_o   = rdy_q;
  assign busy_o        = busy_q;
  assign cfg_err_o     = err_q;
  assign cfg_applied_o = app_q;

  assign req_bad = (in_px_q == 16'd0) || (out_px_q == 16'd0) || (out_px_q > in_px_q) ||
                   (in_ln_q == 16'd0) || (out_ln_q == 16'd0) || (out_ln_q > in_ln_q);

  // One restoring-division step, shared by both axes; quotient shifts in from the dividend.
  always_comb begin
    div_d   = (state_q == DIV_LN) ? skip_ln_q : skip_px_q;
    div_rsh = {div_r_q, div_q_q[15]};
    div_ge  = (div_rsh >= {1'b0, div_d});
    div_r_d = div_ge ? (div_rsh[15:0] - div_d) : div_rsh[15:0];
    div_q_d = {div_q_q[14:0], div_ge};
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q   <= IDLE;
      in_px_q   <= '0;
      out_px_q  <= '0;
      in_ln_q   <= '0;
      out_ln_q  <= '0;
      skip_px_q <= '0;
      skip_ln_q <= '0;
      q_px_q    <= '0;
      r_px_q    <= '0;
      q_ln_q    <= '0;
      r_ln_q    <= '0;
      div_q_q   <= '0;
      div_r_q   <= '0;
      cnt_q     <= '0;
      rdy_q     <= 1'b0;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
      app_q     <= 1'b0;
      ss_o.px_to_skip           <= '0;
      ss_o.px_skip_interval     <= '0;
      ss_o.add_px_skip_interval <= '0;
      ss_o.ln_to_skip           <= '0;
      ss_o.ln_skip_interval     <= '0;
      ss_o.add_ln_skip_interval <= '0;
    end else begin
      err_q <= 1'b0;
      app_q <= 1'b0;
      case (state_q)
        IDLE: begin
          rdy_q  <= 1'b1;
          busy_q <= 1'b0;
          if (cfg_valid_i && rdy_q) begin
            in_px_q  <= in_px_i;
            out_px_q <= out_px_i;
            in_ln_q  <= in_ln_i;
            out_ln_q <= out_ln_i;
            rdy_q    <= 1'b0;
            busy_q   <= 1'b1;
            state_q  <= CHK;
          end
        end
        CHK: begin
          if (req_bad) begin
            err_q   <= 1'b1;
            rdy_q   <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            skip_px_q <= in_px_q - out_px_q;
            skip_ln_q <= in_ln_q - out_ln_q;
            div_q_q   <= in_px_q;
            div_r_q   <= '0;
            cnt_q     <= '0;
            state_q   <= DIV_PX;
          end
        end
        DIV_PX: begin
          div_q_q <= div_q_d;
          div_r_q <= div_r_d;
          cnt_q   <= cnt_q + 4'd1;
          if (cnt_q == 4'd15) begin
            // A zero skip still burns all 16 steps; its garbage result is masked here.
            q_px_q  <= (skip_px_q == 16'd0) ? 16'd0 : div_q_d;
            r_px_q  <= (skip_px_q == 16'd0) ? 16'd0 : div_r_d;
            div_q_q <= in_ln_q;
            div_r_q <= '0;
            state_q <= DIV_LN;
          end
        end
        DIV_LN: begin
          div_q_q <= div_q_d;
          div_r_q <= div_r_d;
          cnt_q   <= cnt_q + 4'd1;
          if (cnt_q == 4'd15) begin
            q_ln_q  <= (skip_ln_q == 16'd0) ? 16'd0 : div_q_d;
            r_ln_q  <= (skip_ln_q == 16'd0) ? 16'd0 : div_r_d;
            state_q <= PEND;
          end
        end
        PEND: begin
          if (sof_hit) begin
            ss_o.px_to_skip           <= skip_px_q;
            ss_o.px_skip_interval     <= q_px_q;
            ss_o.add_px_skip_interval <= r_px_q;
            ss_o.ln_to_skip           <= skip_ln_q;
            ss_o.ln_skip_interval     <= q_ln_q;
            ss_o.add_ln_skip_interval <= r_ln_q;
            app_q   <= 1'b1;
            rdy_q   <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: begin
          rdy_q   <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule
